obj_row_addr_gen: RTL and testbench

//  Sequential successor to the OBJ tile address logic. Accepts one sprite-row request per handshake and streams

---
 rtl/obj_addr_pkg.sv | 18 +
 rtl/obj_tile_num_calc.sv | 36 +++
 rtl/obj_row_addr_gen.sv | 202 ++++++++++++++++++++
 tb/tb_obj_row_addr_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/obj_addr_pkg.sv
// obj_addr_pkg: shared types and constants for the OBJ row address generator.
// Holds the FSM state enum and the fixed OBJ VRAM geometry constants.
// No logic; imported by obj_tile_num_calc and obj_row_addr_gen.
package obj_addr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOS  = 2'd1,
    CALC = 2'd2,
    EMIT = 2'd3
  } obj_state_e;

  localparam int OBJ_TILE_BYTES      = 32;
  localparam int OBJ_NAME_W          = 10;
  localparam int OBJ_2D_ROW_TILES    = 32;
  localparam int OBJ_BITMAP_MIN_TILE = 512;

endpackage

// File: rtl/obj_tile_num_calc.sv
// obj_tile_num_calc: maps (name, tile row, flipped column, step) to a 10-bit OBJ tile number.
// Latency: purely combinational. Backpressure: none, follows its inputs.
// Ports: name, trow, colp (column after hflip), step (1 = 4bpp, 2 = 8bpp), map1d, wtiles -> tile.
module obj_tile_num_calc
  import obj_addr_pkg::*;
#(
  parameter int WT_W = 4
) (
  input  logic [OBJ_NAME_W-1:0] name,
  input  logic [WT_W-1:0]       trow,
  input  logic [WT_W-1:0]       colp,
  input  logic [1:0]            step,
  input  logic                  map1d,
  input  logic [WT_W-1:0]       wtiles,
  output logic [OBJ_NAME_W-1:0] tile
);

  localparam int CW = $clog2(OBJ_2D_ROW_TILES);
  localparam int RW = OBJ_NAME_W - CW;

  logic [OBJ_NAME_W-1:0] off_1d;
  logic [RW-1:0]         row_2d;
  logic [CW-1:0]         col_2d;

  always_comb begin
    // 1D: tiles are packed row after row, each sprite row spans wtiles*step tiles.
    off_1d = OBJ_NAME_W'(trow) * OBJ_NAME_W'(wtiles) * OBJ_NAME_W'(step)
           + OBJ_NAME_W'(colp) * OBJ_NAME_W'(step);
    // 2D: fixed 32-tile rows; 8bpp clears the low column bit of the name and the
    // column wraps inside its own 32-tile row.
    row_2d = name[OBJ_NAME_W-1:CW] + RW'(trow);
    col_2d = (name[CW-1:0] & {{(CW-1){1'b1}}, ~step[1]}) + CW'(colp) * CW'(step);
    tile   = map1d ? (name + off_1d) : {row_2d, col_2d};
  end

endmodule

// File: rtl/obj_row_addr_gen.sv
// obj_row_addr_gen: takes one sprite-row request and streams one word-aligned VRAM address per 32-bit beat.
// Latency: first beat 2 cycles after the request handshake (plus the MOS cycles when OBJ_MOSAIC_EN is defined).
// Backpressure: beat outputs hold while addr_valid && !addr_ready; req_ready only in IDLE; row_abort drops the row.
// Ports: clock, reset (synchronous, active-high); req_* row request; mosaic_v; row_abort;
//        addr_valid/addr_ready handshake with addr, addr_oob (bitmap-mode transparent beat), addr_last.
module obj_row_addr_gen
  import obj_addr_pkg::*;
#(
  parameter  int ADDR_W     = 15,
  parameter  int MAX_WTILES = 8,
  localparam int WT_W       = $clog2(MAX_WTILES) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OBJ_NAME_W-1:0] req_name,
  input  logic                  req_bpp8,
  input  logic                  req_map1d,
  input  logic [2:0]            req_bgmode,
  input  logic [WT_W-1:0]       req_wtiles,
  input  logic [WT_W-1:0]       req_htiles,
  input  logic [5:0]            req_y,
  input  logic                  req_hflip,
  input  logic                  req_vflip,
  input  logic [3:0]            mosaic_v,
  input  logic                  row_abort,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic [ADDR_W-1:0]     addr,
  output logic                  addr_oob,
  output logic                  addr_last
);

  localparam int YW = WT_W + 3;

  obj_state_e state_q, state_d;

  logic [OBJ_NAME_W-1:0] name_q;
  logic                  bpp8_q, map1d_q, hflip_q, vflip_q;
  logic [2:0]            bgmode_q;
  logic [WT_W-1:0]       w_q, h_q;
  logic [5:0]            y_q;
  logic [WT_W-1:0]       trow_q;
  logic [2:0]            yin_q;
  logic [WT_W:0]         beat_q;

`ifdef OBJ_MOSAIC_EN
  // y_eff is found by stepping an accumulator up the mosaic grid until the next
  // step would pass y; the last grid point reached is the mosaic-snapped row.
  logic [5:0] acc_q;
  logic [4:0] mstep_q;
  logic [6:0] acc_next;
  logic       mos_more;
  assign acc_next = {1'b0, acc_q} + {2'b00, mstep_q};
  assign mos_more = (acc_next <= {1'b0, y_q});
`else
  logic unused_mosaic;
  assign unused_mosaic = ^mosaic_v;
`endif

  // Row selection, done once in CALC. Out-of-range y wraps modulo the sprite height.
  logic [YW-1:0] rows8, y_m, y_p;
  assign rows8 = {h_q, 3'b000};
  assign y_m   = YW'(y_q) % rows8;
  assign y_p   = vflip_q ? (rows8 - YW'(1) - y_m) : y_m;

  // Per-beat column/half selection from the beat index.
  logic [1:0]            step;
  logic [WT_W:0]         n_beats;
  logic [WT_W-1:0]       col, colp;
  logic                  half, halfp;
  logic [5:0]            inrow;
  logic                  beat_last;
  logic [OBJ_NAME_W-1:0] tile;
  logic [ADDR_W-1:0]     addr_c;
  logic                  oob_c;

  always_comb begin
    step      = bpp8_q ? 2'd2 : 2'd1;
    n_beats   = bpp8_q ? {w_q, 1'b0} : {1'b0, w_q};
    col       = bpp8_q ? beat_q[WT_W:1] : beat_q[WT_W-1:0];
    half      = bpp8_q & beat_q[0];
    colp      = hflip_q ? (w_q - col - WT_W'(1)) : col;
    halfp     = hflip_q ? (bpp8_q & ~half) : half;
    inrow     = (bpp8_q ? {yin_q, 3'b000} : {1'b0, yin_q, 2'b00}) + {3'b000, halfp, 2'b00};
    beat_last = (beat_q == n_beats - (WT_W+1)'(1));
    addr_c    = ADDR_W'(32'(tile) * OBJ_TILE_BYTES) + ADDR_W'(inrow);
    oob_c     = (bgmode_q >= 3'd3) && (tile < OBJ_NAME_W'(OBJ_BITMAP_MIN_TILE));
  end

  obj_tile_num_calc #(.WT_W(WT_W)) u_tile (
    .name   (name_q),
    .trow   (trow_q),
    .colp   (colp),
    .step   (step),
    .map1d  (map1d_q),
    .wtiles (w_q),
    .tile   (tile)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    addr_valid = 1'b0;
    addr       = '0;
    addr_oob   = 1'b0;
    addr_last  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
`ifdef OBJ_MOSAIC_EN
          state_d = MOS;
`else
          state_d = CALC;
`endif
        end
      end
      MOS: begin
`ifdef OBJ_MOSAIC_EN
        if (row_abort)     state_d = IDLE;
        else if (!mos_more) state_d = CALC;
`else
        state_d = IDLE;
`endif
      end
      CALC: state_d = row_abort ? IDLE : EMIT;
      EMIT: begin
        addr_valid = 1'b1;
        addr       = addr_c;
        addr_oob   = oob_c;
        addr_last  = beat_last;
        // Abort wins over a beat handshake in the same cycle.
        if (row_abort || (addr_ready && beat_last)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      name_q   <= '0;
      bpp8_q   <= 1'b0;
      map1d_q  <= 1'b0;
      hflip_q  <= 1'b0;
      vflip_q  <= 1'b0;
      bgmode_q <= '0;
      w_q      <= WT_W'(1);
      h_q      <= WT_W'(1);
      y_q      <= '0;
      trow_q   <= '0;
      yin_q    <= '0;
      beat_q   <= '0;
`ifdef OBJ_MOSAIC_EN
      acc_q    <= '0;
      mstep_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            name_q   <= req_name;
            bpp8_q   <= req_bpp8;
            map1d_q  <= req_map1d;
            hflip_q  <= req_hflip;
            vflip_q  <= req_vflip;
            bgmode_q <= req_bgmode;
            w_q      <= (req_wtiles == '0) ? WT_W'(1) : req_wtiles;
            h_q      <= (req_htiles == '0) ? WT_W'(1) : req_htiles;
            y_q      <= req_y;
            beat_q   <= '0;
`ifdef OBJ_MOSAIC_EN
            acc_q    <= '0;
            mstep_q  <= {1'b0, mosaic_v} + 5'd1;
`endif
          end
        end
        MOS: begin
`ifdef OBJ_MOSAIC_EN
          if (mos_more) acc_q <= acc_next[5:0];
          else          y_q   <= acc_q;
`endif
        end
        CALC: begin
          trow_q <= y_p[YW-1:3];
          yin_q  <= y_p[2:0];
        end
        EMIT: begin
          if (addr_ready) beat_q <= beat_q + (WT_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_obj_row_addr_gen.sv
// tb_obj_row_addr_gen: directed and random sprite rows checked against a behavioural address model.
// Covers reset state, latency, 4/8bpp, 1D/2D, flips, bitmap-mode oob, stalls, aborts and mid-row reset.
// Define OBJ_MOSAIC_EN for both bench and RTL to cover the mosaic build.
`timescale 1ns/1ps
module tb_obj_row_addr_gen;

  localparam int ADDR_W = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_name;
  logic        req_bpp8;
  logic        req_map1d;
  logic [2:0]  req_bgmode;
  logic [3:0]  req_wtiles;
  logic [3:0]  req_htiles;
  logic [5:0]  req_y;
  logic        req_hflip;
  logic        req_vflip;
  logic [3:0]  mosaic_v;
  logic        row_abort;
  logic        addr_valid;
  logic        addr_ready;
  logic [ADDR_W-1:0] addr;
  logic        addr_oob;
  logic        addr_last;

  always #5 clock = ~clock;

  obj_row_addr_gen #(.ADDR_W(ADDR_W), .MAX_WTILES(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_name   (req_name),
    .req_bpp8   (req_bpp8),
    .req_map1d  (req_map1d),
    .req_bgmode (req_bgmode),
    .req_wtiles (req_wtiles),
    .req_htiles (req_htiles),
    .req_y      (req_y),
    .req_hflip  (req_hflip),
    .req_vflip  (req_vflip),
    .mosaic_v   (mosaic_v),
    .row_abort  (row_abort),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr       (addr),
    .addr_oob   (addr_oob),
    .addr_last  (addr_last)
  );

  int tests = 0;
  int fails = 0;
  int exp_addr[$];
  int exp_oob[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: walk the beats of a row using the tile/address rules directly.
  function automatic void build_row(input int nm, input int bpp8, input int map1d, input int bgmode,
                                    input int wt, input int ht, input int y, input int hf, input int vf);
    int w, h, step, ye, ym, yp, trow, yin, col, half, tile, base;
    exp_addr.delete();
    exp_oob.delete();
    w    = (wt == 0) ? 1 : wt;
    h    = (ht == 0) ? 1 : ht;
    step = bpp8 ? 2 : 1;
    ye   = y;
`ifdef OBJ_MOSAIC_EN
    ye = y - (y % (int'(mosaic_v) + 1));
`endif
    ym   = ye % (8 * h);
    yp   = vf ? (8 * h - 1 - ym) : ym;
    trow = yp / 8;
    yin  = yp % 8;
    for (int b = 0; b < w * step; b++) begin
      col  = b / step;
      half = b % step;
      if (hf) begin
        col  = w - 1 - col;
        half = step - 1 - half;
      end
      if (map1d) begin
        tile = (nm + trow * w * step + col * step) % 1024;
      end else begin
        base = (nm % 32) - (bpp8 ? (nm % 2) : 0);
        tile = (((nm / 32) + trow) % 32) * 32 + (base + col * step) % 32;
      end
      exp_addr.push_back((tile * 32 + yin * (bpp8 ? 8 : 4) + half * 4) % (1 << ADDR_W));
      exp_oob.push_back((bgmode >= 3 && tile < 512) ? 1 : 0);
    end
  endfunction

  // Starts and ends just after a falling edge. abort_at < 0 runs the row to completion.
  task automatic run_row(input int nm, input int bpp8, input int map1d, input int bgmode,
                         input int wt, input int ht, input int y, input int hf, input int vf,
                         input int stall_pct, input int abort_at, input bit abort_idle);
    int lat, exp_lat, n, st;
    build_row(nm, bpp8, map1d, bgmode, wt, ht, y, hf, vf);
    n       = exp_addr.size();
    exp_lat = 2;
`ifdef OBJ_MOSAIC_EN
    exp_lat += y / (int'(mosaic_v) + 1) + 1;
`endif
    check("req_ready_idle", 32'(req_ready), 1);
    req_name   = nm[9:0];
    req_bpp8   = bpp8[0];
    req_map1d  = map1d[0];
    req_bgmode = bgmode[2:0];
    req_wtiles = wt[3:0];
    req_htiles = ht[3:0];
    req_y      = y[5:0];
    req_hflip  = hf[0];
    req_vflip  = vf[0];
    req_valid  = 1'b1;
    row_abort  = abort_idle;
    addr_ready = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    row_abort = 1'b0;
    lat = 1;
    while (!addr_valid && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    check("first_beat_latency", lat, exp_lat);
    for (int b = 0; b < n; b++) begin
      st = ($urandom_range(99) < stall_pct) ? int'($urandom_range(4, 1)) : 0;
      addr_ready = 1'b0;
      for (int s = 0; s < st; s++) begin
        check("stall_valid", 32'(addr_valid), 1);
        check("stall_addr", 32'(addr), exp_addr[b]);
        check("stall_last", 32'(addr_last), 32'(b == n - 1));
        @(negedge clock);
      end
      addr_ready = 1'b1;
      check("beat_valid", 32'(addr_valid), 1);
      check("beat_addr", 32'(addr), exp_addr[b]);
      check("beat_oob", 32'(addr_oob), exp_oob[b]);
      check("beat_last", 32'(addr_last), 32'(b == n - 1));
      if (b == abort_at) row_abort = 1'b1;
      @(negedge clock);
      if (b == abort_at) begin
        row_abort = 1'b0;
        check("abort_valid", 32'(addr_valid), 0);
        check("abort_ready", 32'(req_ready), 1);
        return;
      end
    end
    check("end_valid", 32'(addr_valid), 0);
    check("end_ready", 32'(req_ready), 1);
    check("end_addr", 32'(addr), 0);
  endtask

  // Accepts a row, then k cycles after the handshake kills it with reset or row_abort.
  task automatic interrupt_row(input int k, input bit use_reset);
    req_name   = 10'd40;
    req_bpp8   = 1'b0;
    req_map1d  = 1'b1;
    req_bgmode = 3'd4;
    req_wtiles = 4'd3;
    req_htiles = 4'd2;
    req_y      = 6'd6;
    req_hflip  = 1'b0;
    req_vflip  = 1'b0;
    req_valid  = 1'b1;
    addr_ready = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (k - 1) @(negedge clock);
    check("busy_ready", 32'(req_ready), 0);
    if (use_reset) reset = 1'b1;
    else           row_abort = 1'b1;
    @(negedge clock);
    reset     = 1'b0;
    row_abort = 1'b0;
    check("kill_valid", 32'(addr_valid), 0);
    check("kill_addr", 32'(addr), 0);
    check("kill_oob", 32'(addr_oob), 0);
    check("kill_last", 32'(addr_last), 0);
    check("kill_ready", 32'(req_ready), 1);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_name   = '0;
    req_bpp8   = 1'b0;
    req_map1d  = 1'b0;
    req_bgmode = '0;
    req_wtiles = '0;
    req_htiles = '0;
    req_y      = '0;
    req_hflip  = 1'b0;
    req_vflip  = 1'b0;
    mosaic_v   = 4'd0;
    row_abort  = 1'b0;
    addr_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_ready", 32'(req_ready), 1);
    check("rst_valid", 32'(addr_valid), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_oob", 32'(addr_oob), 0);
    check("rst_last", 32'(addr_last), 0);
    reset = 1'b0;
    @(negedge clock);

    // 4bpp 1D, mid-height row
    run_row(5, 0, 1, 0, 2, 2, 9, 0, 0, 0, -1, 0);
    // 8bpp 2D with hflip
    run_row(3, 1, 0, 0, 2, 1, 0, 1, 0, 0, -1, 0);
    // bitmap mode: tile 511 is oob, tile 512 is not
    run_row(511, 0, 1, 3, 2, 1, 0, 0, 0, 0, -1, 0);
    // heavy stalls, then abort on beat 1 while the beat handshakes
    run_row(100, 1, 1, 0, 4, 2, 3, 0, 0, 100, 1, 0);
    // vflip picks the bottom row of the bottom tile
    run_row(0, 0, 1, 0, 1, 4, 0, 0, 1, 0, -1, 0);
    // 1D tile number wraps at 1024
    run_row(1023, 0, 1, 0, 2, 1, 0, 0, 0, 0, -1, 0);
    // 2D column wraps within the 32-tile row, both flips
    run_row(30, 0, 0, 5, 4, 3, 17, 1, 1, 30, -1, 0);
    // zero sizes clamp to 1, y wraps modulo the height
    run_row(77, 1, 0, 0, 0, 0, 13, 0, 0, 0, -1, 0);
    // row_abort in IDLE does not block the request
    run_row(200, 0, 1, 3, 3, 2, 5, 0, 0, 0, -1, 1);

`ifdef OBJ_MOSAIC_EN
    mosaic_v = 4'd3;
    run_row(8, 0, 1, 0, 2, 2, 6, 0, 0, 0, -1, 0);
`endif
    mosaic_v = 4'd3;
    interrupt_row(1, 1'b1);
    interrupt_row(2, 1'b0);
    interrupt_row(3, 1'b1);

    for (int i = 0; i < 40; i++) begin
      mosaic_v = 4'($urandom_range(15));
      run_row(int'($urandom_range(1023)), int'($urandom_range(1)), int'($urandom_range(1)),
              int'($urandom_range(5)), int'($urandom_range(8)), int'($urandom_range(8)),
              int'($urandom_range(63)), int'($urandom_range(1)), int'($urandom_range(1)),
              30, ($urandom_range(9) == 0) ? int'($urandom_range(1)) : -1,
              $urandom_range(3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
